// File: rtl/disk_pkg.sv
// Shared types and constants for the emulated block-device responder.
package disk_pkg;

    localparam int SECTOR_WORDS = 256;
    localparam int SECTOR_SHIFT = 9;

    typedef enum logic [4:0] {
        S_IDLE,
        S_MR_ADDR, S_MR_P1, S_MR_P2, S_MR_LAT,
        S_B_LO, S_G_LO, S_B_HI, S_G_HI,
        S_F_LO, S_C_LO, S_F_HI, S_C_HI,
        S_MW_ADDR, S_MW_P1, S_MW_P2, S_MW_DONE,
        S_FIN, S_WAIT_REL
    } sdt_state_t;

    // States that sit on the odd byte of the current word.
    function automatic logic is_hi_half(sdt_state_t s);
        return (s == S_B_HI) || (s == S_G_HI) || (s == S_F_HI) || (s == S_C_HI) ||
               (s == S_MW_ADDR) || (s == S_MW_P1) || (s == S_MW_P2) || (s == S_MW_DONE);
    endfunction

endpackage

// File: rtl/sd_block_target.sv
// Serves 512-byte sd_* sector requests from a RAM-disk image in SDRAM.
// Handshake: a request (sd_rd/sd_wr level) is accepted in IDLE on a ce cycle; sd_ack stays high until the sector is done.
module sd_block_target
    import disk_pkg::*;
#(
    parameter logic [24:0] BASE_ADDR = 25'h140000,
    parameter logic [31:0] MAX_SECT  = 32'h0000_3000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        img_mounted,
    input  logic [31:0] img_size,
    output logic        sd_mounted,
    input  logic [31:0] sd_lba,
    input  logic        sd_rd,
    input  logic        sd_wr,
    input  logic        sd_conf,
    output logic        sd_ack,
    output logic        sd_ack_conf,
    output logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_dout,
    output logic        sd_buff_wr,
    input  logic [7:0]  sd_buff_din,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_we,
    input  logic [15:0] mem_din,
    output logic [15:0] mem_dout,
    output logic        busy
);

    sdt_state_t  state, state_nxt;
    logic [31:0] img_sectors;
    logic [15:0] lba;
    logic        in_range;
    logic [7:0]  k;
    logic [15:0] word;
    logic [7:0]  lo_byte, hi_byte;

    logic [31:0] size_sectors;
    logic        accept, acc_read, acc_range, last_word, word_end, mem_phase;
    logic        unused_size;

    assign unused_size  = ^img_size[SECTOR_SHIFT-1:0];
    assign size_sectors = {{SECTOR_SHIFT{1'b0}}, img_size[31:SECTOR_SHIFT]};

    assign accept    = (state == S_IDLE) && (sd_rd || sd_wr);
    // A config request is served as a read that never touches memory.
    assign acc_read  = sd_rd || sd_conf;
    assign acc_range = !sd_conf && (sd_lba < img_sectors);
    assign last_word = (k == 8'(SECTOR_WORDS - 1));
    assign word_end  = (state == S_G_HI) || (state == S_MW_DONE) ||
                       ((state == S_C_HI) && !in_range);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = acc_read ? (acc_range ? S_MR_ADDR : S_B_LO) : S_F_LO;
            S_MR_ADDR:  state_nxt = S_MR_P1;
            S_MR_P1:    state_nxt = S_MR_P2;
            S_MR_P2:    state_nxt = S_MR_LAT;
            S_MR_LAT:   state_nxt = S_B_LO;
            S_B_LO:     state_nxt = S_G_LO;
            S_G_LO:     state_nxt = S_B_HI;
            S_B_HI:     state_nxt = S_G_HI;
            S_G_HI:     state_nxt = last_word ? S_FIN : (in_range ? S_MR_ADDR : S_B_LO);
            S_F_LO:     state_nxt = S_C_LO;
            S_C_LO:     state_nxt = S_F_HI;
            S_F_HI:     state_nxt = S_C_HI;
            S_C_HI:     state_nxt = in_range ? S_MW_ADDR : (last_word ? S_FIN : S_F_LO);
            S_MW_ADDR:  state_nxt = S_MW_P1;
            S_MW_P1:    state_nxt = S_MW_P2;
            S_MW_P2:    state_nxt = S_MW_DONE;
            S_MW_DONE:  state_nxt = last_word ? S_FIN : S_F_LO;
            S_FIN:      state_nxt = S_WAIT_REL;
            S_WAIT_REL: if (!(sd_rd || sd_wr)) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            img_sectors <= '0;
            sd_mounted  <= 1'b0;
            lba         <= '0;
            in_range    <= 1'b0;
            k           <= '0;
            word        <= '0;
            lo_byte     <= '0;
            hi_byte     <= '0;
        end else begin
            // Mount is taken regardless of ce so a short pulse is never lost.
            if (img_mounted) begin
                img_sectors <= (size_sectors > MAX_SECT) ? MAX_SECT : size_sectors;
                sd_mounted  <= (size_sectors != 32'd0);
            end
            if (ce) begin
                if (accept) begin
                    lba      <= sd_lba[15:0];
                    in_range <= acc_range;
                    k        <= '0;
                    word     <= '0;
                end
                if (state == S_MR_LAT) word    <= mem_din;
                if (state == S_C_LO)   lo_byte <= sd_buff_din;
                if (state == S_C_HI)   hi_byte <= sd_buff_din;
                if (word_end)          k       <= k + 8'd1;
            end
        end
    end

    assign mem_phase = (state == S_MR_ADDR) || (state == S_MR_P1) || (state == S_MR_P2) ||
                       (state == S_MR_LAT)  || (state == S_MW_ADDR) || (state == S_MW_P1) ||
                       (state == S_MW_P2)   || (state == S_MW_DONE);

    always_comb begin
        busy         = (state != S_IDLE);
        sd_ack       = busy && (state != S_FIN) && (state != S_WAIT_REL);
        sd_ack_conf  = 1'b0;
        sd_buff_addr = sd_ack ? {k, is_hi_half(state)} : 9'd0;
        sd_buff_wr   = ce && ((state == S_B_LO) || (state == S_B_HI));
        sd_buff_dout = 8'd0;
        if (state == S_B_LO) sd_buff_dout = word[7:0];
        if (state == S_B_HI) sd_buff_dout = word[15:8];
        mem_addr     = 25'd0;
        if (mem_phase) mem_addr = BASE_ADDR + {lba, {SECTOR_SHIFT{1'b0}}} + {16'd0, k, 1'b0};
        mem_rd       = (state == S_MR_P1) || (state == S_MR_P2);
        mem_we       = (state == S_MW_P1) || (state == S_MW_P2);
        mem_dout     = {hi_byte, lo_byte};
    end

endmodule

// File: tb/tb_sd_block_target.sv
// Randomised bench for sd_block_target with an SDRAM model, a requester buffer model and a sector-level reference.
module tb_sd_block_target;

  localparam logic [24:0] BASE = 25'h140000;
  localparam logic [31:0] MAXS = 32'h0000_3000;

  // ---------------- clock / reset ----------------
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        img_mounted = 1'b0;
  logic [31:0] img_size = '0;
  logic [31:0] sd_lba = '0;
  logic        sd_rd = 1'b0, sd_wr = 1'b0, sd_conf = 1'b0;
  logic [7:0]  sd_buff_din = '0;
  logic [15:0] mem_din = '0;
  logic        sd_mounted, sd_ack, sd_ack_conf, sd_buff_wr, mem_rd, mem_we, busy;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [24:0] mem_addr;
  logic [15:0] mem_dout;

  always #5 clk_sys = ~clk_sys;

  sd_block_target dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce),
    .img_mounted(img_mounted), .img_size(img_size), .sd_mounted(sd_mounted),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_conf(sd_conf),
    .sd_ack(sd_ack), .sd_ack_conf(sd_ack_conf),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  bit ce_rand = 1'b0;
  initial forever begin
    @(posedge clk_sys);
    #1;
    ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- environment models ----------------
  bit [15:0] sdram [bit [23:0]];
  bit [7:0]  wbuf [512];
  bit [7:0]  rbuf [512];

  always @(posedge clk_sys) begin
    if (mem_rd) mem_din <= sdram[mem_addr[24:1]];
    if (mem_we) sdram[mem_addr[24:1]] = mem_dout;
    sd_buff_din <= wbuf[sd_buff_addr];
  end

  // ---------------- reference model ----------------
  int unsigned model_sectors = 0;

  function automatic int unsigned sectors_for(logic [31:0] sz);
    longint s;
    s = longint'(sz) / 512;
    return (s > longint'(MAXS)) ? int'(MAXS) : int'(s);
  endfunction

  function automatic logic [24:0] word_addr(logic [31:0] lba, int k);
    longint a;
    a = longint'(BASE) + longint'(lba % 65536) * 512 + 2 * k;
    return a[24:0];
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [24:0] exp_raddr_q[$];
  logic [24:0] exp_waddr_q[$];
  logic [15:0] exp_wd_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic note_extra(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT produced an access the model did not expect (t=%0t)", name, $time);
  endtask

  int ack_ce_cnt = 0, ack_rises = 0, wr_pulses = 0, rd_bursts = 0, we_bursts = 0;
  int buff_idx = 0;
  bit prev_ack = 0, prev_rd = 0, prev_we = 0, prev_bwr = 0;

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (sd_ack && !prev_ack) begin
        ack_rises++;
        buff_idx = 0;
      end
      if (sd_ack && ce) ack_ce_cnt++;
      if (sd_buff_wr) begin
        wr_pulses++;
        check("buff_wr_ce", ce, 1);
        check("buff_wr_width", prev_bwr, 0);
        check("buff_addr", sd_buff_addr, buff_idx);
        if (exp_q.size() == 0) note_extra("buff_byte");
        else check("buff_dout", sd_buff_dout, exp_q.pop_front());
        rbuf[sd_buff_addr] = sd_buff_dout;
        buff_idx++;
      end
      if (mem_rd && !prev_rd) begin
        rd_bursts++;
        if (exp_raddr_q.size() == 0) note_extra("mem_rd");
        else check("mem_rd_addr", mem_addr, exp_raddr_q.pop_front());
      end
      if (mem_we && !prev_we) begin
        we_bursts++;
        if (exp_waddr_q.size() == 0) note_extra("mem_we");
        else begin
          check("mem_we_addr", mem_addr, exp_waddr_q.pop_front());
          check("mem_we_data", mem_dout, exp_wd_q.pop_front());
        end
      end
      prev_ack = sd_ack;
      prev_rd  = mem_rd;
      prev_we  = mem_we;
      prev_bwr = sd_buff_wr;
    end else begin
      prev_ack = 0;
      prev_rd  = 0;
      prev_we  = 0;
      prev_bwr = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mount(input logic [31:0] sz);
    @(posedge clk_sys); #1;
    img_size = sz;
    img_mounted = 1'b1;
    @(posedge clk_sys); #1;
    img_mounted = 1'b0;
    model_sectors = sectors_for(sz);
    @(negedge clk_sys);
    check("sd_mounted", sd_mounted, model_sectors != 0);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    exp_raddr_q.delete();
    exp_waddr_q.delete();
    exp_wd_q.delete();
  endtask

  task automatic prepare(input bit is_read, input bit in_rng, input logic [31:0] lba, input bit pattern);
    logic [24:0] a;
    logic [15:0] w;
    clear_sb();
    if (!is_read)
      for (int i = 0; i < 512; i++) wbuf[i] = pattern ? 8'(i) : 8'($urandom_range(0, 255));
    for (int k = 0; k < 256; k++) begin
      a = word_addr(lba, k);
      if (is_read) begin
        w = in_rng ? sdram[a[24:1]] : 16'h0000;
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        if (in_rng) exp_raddr_q.push_back(a);
      end else if (in_rng) begin
        exp_waddr_q.push_back(a);
        exp_wd_q.push_back({wbuf[2*k+1], wbuf[2*k]});
      end
    end
  endtask

  task automatic xfer(input bit rd, input bit wr, input bit conf, input logic [31:0] lba,
                      input int hold, input bit pattern);
    bit is_read, in_rng;
    int a0, r0, w0, rb0, wb0, t, bad;
    logic [24:0] a;
    is_read = rd || conf;
    in_rng  = !conf && (lba < model_sectors);
    prepare(is_read, in_rng, lba, pattern);
    a0 = ack_ce_cnt; r0 = ack_rises; w0 = wr_pulses; rb0 = rd_bursts; wb0 = we_bursts;
    @(posedge clk_sys); #1;
    sd_lba = lba; sd_rd = rd; sd_wr = wr; sd_conf = conf;
    t = 0;
    while (!sd_ack && t < 100) begin @(negedge clk_sys); t++; end
    check("ack_rise", sd_ack, 1);
    t = 0;
    while (sd_ack && t < 20000) begin @(negedge clk_sys); t++; end
    check("ack_fall", sd_ack, 0);
    repeat (hold) @(negedge clk_sys);
    @(posedge clk_sys); #1;
    sd_rd = 0; sd_wr = 0; sd_conf = 0;
    t = 0;
    while (busy && t < 100) begin @(negedge clk_sys); t++; end
    check("busy_idle", busy, 0);
    check("ack_ce_cycles", ack_ce_cnt - a0, in_rng ? 2048 : 1024);
    check("ack_rises", ack_rises - r0, 1);
    check("buff_wr_pulses", wr_pulses - w0, is_read ? 512 : 0);
    check("mem_rd_bursts", rd_bursts - rb0, (is_read && in_rng) ? 256 : 0);
    check("mem_we_bursts", we_bursts - wb0, (!is_read && in_rng) ? 256 : 0);
    check("exp_left", exp_q.size() + exp_raddr_q.size() + exp_waddr_q.size(), 0);
    if (!is_read && in_rng) begin
      bad = 0;
      for (int k = 0; k < 256; k++) begin
        a = word_addr(lba, k);
        if (sdram[a[24:1]] != {wbuf[2*k+1], wbuf[2*k]}) bad++;
      end
      check("wr_image_words_bad", bad, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [24:0] a;
    int t, w0, lba_r;
    for (int i = 0; i < 64 * 256; i++) sdram[24'((BASE >> 1) + i)] = 16'($urandom_range(0, 65535));
    a = BASE + 25'h400;
    sdram[a[24:1]] = 16'h1234;

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_ack", sd_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_mounted", sd_mounted, 0);
    check("rst_strobes", {sd_buff_wr, mem_rd, mem_we, sd_ack_conf}, 0);
    check("rst_addrs", {mem_addr, sd_buff_addr}, 0);
    check("rst_data", {mem_dout, sd_buff_dout}, 0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;

    check("model_16_sectors", sectors_for(32'h2000), 16);
    check("model_max_clamp", sectors_for(32'hFFFF_FFFF), 32'h3000);
    mount(32'h2000);

    xfer(1, 0, 0, 2, 0, 0);
    check("lba2_byte0", rbuf[0], 8'h34);
    check("lba2_byte1", rbuf[1], 8'h12);

    xfer(0, 1, 0, 3, 0, 1);
    a = BASE + 25'h600;
    check("lba3_word0", sdram[a[24:1]], 16'h0100);
    a = BASE + 25'h602;
    check("lba3_word1", sdram[a[24:1]], 16'h0302);

    xfer(1, 0, 0, 16, 0, 0);
    xfer(0, 1, 0, 16, 0, 0);
    xfer(1, 0, 0, 5, 300, 0);
    xfer(1, 1, 0, 4, 0, 0);
    xfer(1, 0, 1, 1, 0, 0);

    mount(32'h0);
    xfer(1, 0, 0, 0, 0, 0);
    mount(32'hFFFF_FFFF);
    xfer(1, 0, 0, 32'h3000, 0, 0);
    xfer(1, 0, 0, 32'h2FFF, 0, 0);

    ce_rand = 1'b1;
    mount(32'($urandom_range(20, 40) * 512 + $urandom_range(0, 511)));
    for (int n = 0; n < 6; n++) begin
      lba_r = $urandom_range(0, model_sectors + 4);
      if ($urandom_range(0, 1) == 0) xfer(1, 0, 0, lba_r, $urandom_range(0, 5), 0);
      else xfer(0, 1, 0, lba_r, $urandom_range(0, 5), 0);
    end
    ce_rand = 1'b0;

    // Reset in the middle of word 100 of a read.
    prepare(1, 1, 1, 0);
    w0 = wr_pulses;
    @(posedge clk_sys); #1;
    sd_lba = 1; sd_rd = 1;
    t = 0;
    while ((wr_pulses - w0) < 201 && t < 5000) begin @(negedge clk_sys); t++; end
    check("midrst_reach_word100", (wr_pulses - w0) >= 201, 1);
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    sd_rd = 0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("midrst_ack", sd_ack, 0);
    check("midrst_busy", busy, 0);
    check("midrst_strobes", {sd_buff_wr, mem_rd, mem_we}, 0);
    check("midrst_mounted", sd_mounted, 0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    clear_sb();
    model_sectors = 0;
    mount(32'h2000);
    xfer(1, 0, 0, 2, 0, 0);
    check("post_rst_byte0", rbuf[0], 8'h34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
